// File: rtl/writeback_regfile.sv
// Writeback select and 16-entry, 3-lane vector register file with lane-masked writes,
// two bypassed combinational read ports and a post-reset zero-fill sweep.
module writeback_regfile #(
  parameter int N    = 18,
  parameter int REGS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWriteW,
  input  logic                MemtoRegW,
  input  logic [3:0]          WA3W,
  input  logic [2:0]          LaneMaskW,
  input  logic [2:0][N-1:0]   ReadDataW,
  input  logic [2:0][N-1:0]   ALUOutW,
  input  logic [3:0]          RA1,
  input  logic [3:0]          RA2,
  output logic [2:0][N-1:0]   RD1,
  output logic [2:0][N-1:0]   RD2,
  output logic [2:0][N-1:0]   ResultW,
  output logic                ready,
  output logic                dbg_state
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] LAST = 4'(REGS - 1);

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic            wa_ok;
  logic [2:0][N-1:0] mem [REGS];

  assign ResultW   = MemtoRegW ? ReadDataW : ALUOutW;
  assign ready     = (state_q == RUN);
  assign dbg_state = logic'(state_q);
  assign wa_ok     = ({1'b0, WA3W} < 5'(REGS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The sweep index holds at the last entry so it never wraps.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        if (idx_q == LAST) state_d = RUN;
        else               idx_d   = idx_q + 4'd1;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Storage has no reset so it can map to RAM; reset only gates the write strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem[idx_q] <= '0;
      end else if (RegWriteW && wa_ok) begin
        for (int i = 0; i < 3; i++) begin
          if (LaneMaskW[i]) mem[WA3W][i] <= ResultW[i];
        end
      end
    end
  end

  function automatic logic [2:0][N-1:0] read_port(input logic [3:0] ra);
    logic [2:0][N-1:0] r;
    r = '0;
    if (state_q == RUN && ({1'b0, ra} < 5'(REGS))) begin
      r = mem[ra];
      for (int i = 0; i < 3; i++) begin
        if (RegWriteW && (WA3W == ra) && LaneMaskW[i]) r[i] = ResultW[i];
      end
    end
    return r;
  endfunction

  always_comb begin
    RD1 = read_port(RA1);
    RD2 = read_port(RA2);
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios plus randomized traffic checked
// against an array-based model of the register file.
module tb_writeback_regfile;

  localparam int N = 18;
  localparam int W = 3 * N;

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWriteW, MemtoRegW;
  logic [3:0]        WA3W, RA1, RA2;
  logic [2:0]        LaneMaskW;
  logic [2:0][N-1:0] ReadDataW, ALUOutW;
  logic [2:0][N-1:0] RD1, RD2, ResultW;
  logic              ready, dbg_state;

  writeback_regfile #(.N(N), .REGS(16)) dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .WA3W(WA3W), .LaneMaskW(LaneMaskW), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2), .ResultW(ResultW),
    .ready(ready), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: file contents, readiness, edges since reset release
  logic [2:0][N-1:0] m_mem [16];
  bit                m_ready;
  int                m_edges;
  logic [W-1:0]      exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0][N-1:0] m_result();
    return MemtoRegW ? ReadDataW : ALUOutW;
  endfunction

  function automatic logic [2:0][N-1:0] m_read(input logic [3:0] ra);
    logic [2:0][N-1:0] r;
    logic [2:0][N-1:0] res;
    if (!m_ready) return '0;
    r   = m_mem[ra];
    res = m_result();
    for (int i = 0; i < 3; i++)
      if (RegWriteW && WA3W == ra && LaneMaskW[i]) r[i] = res[i];
    return r;
  endfunction

  // Apply the effect of the coming rising edge to the model, then step past it.
  task automatic tick();
    logic [2:0][N-1:0] res;
    res = m_result();
    if (reset) begin
      m_ready = 0;
      m_edges = 0;
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == 16) begin
        m_ready = 1;
        for (int r = 0; r < 16; r++) m_mem[r] = '0;
      end
    end else if (RegWriteW) begin
      for (int i = 0; i < 3; i++)
        if (LaneMaskW[i]) m_mem[WA3W][i] = res[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    m_ready = 0;
    m_edges = 0;
    #1;
  endtask

  task automatic drive_idle();
    RegWriteW = 0; MemtoRegW = 0; WA3W = 0; LaneMaskW = 0;
    ReadDataW = '0; ALUOutW = '0; RA1 = 0; RA2 = 0;
  endtask

  task automatic drive_random();
    RegWriteW = ($urandom_range(0, 2) != 0);
    MemtoRegW = 1'($urandom_range(0, 1));
    WA3W      = 4'($urandom_range(0, 15));
    LaneMaskW = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) begin
      ReadDataW[i] = N'($urandom);
      ALUOutW[i]   = N'($urandom);
    end
    RA1 = ($urandom_range(0, 3) == 0) ? WA3W : 4'($urandom_range(0, 15));
    RA2 = ($urandom_range(0, 3) == 0) ? RA1  : 4'($urandom_range(0, 15));
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, ".ready"},   W'(ready),     W'(m_ready));
    check({tag, ".state"},   W'(dbg_state), W'(m_ready));
    check({tag, ".resultw"}, ResultW,       m_result());
    check({tag, ".rd1"},     RD1,           m_read(RA1));
    check({tag, ".rd2"},     RD2,           m_read(RA2));
  endtask

  initial begin
    logic [2:0][N-1:0] v;
    drive_idle();
    assert_reset();
    tick(); tick();
    check("reset.ready", W'(ready), '0);
    check("reset.rd1", RD1, '0);
    reset = 1'b0;

    // sweep: writes attempted (incl. entry 3) must be dropped
    for (int e = 0; e < 16; e++) begin
      drive_random();
      if (e == 4) begin RegWriteW = 1; WA3W = 3; LaneMaskW = 3'b111; end
      RA1 = 4'(e);
      check_all("sweep");
      check("sweep.not_ready", W'(ready), '0);
      tick();
    end
    drive_idle();
    check("sweep.done", W'(ready), W'(1));
    for (int r = 0; r < 16; r++) begin
      RA1 = 4'(r);
      RA2 = 4'(r);
      check_all("zero");
      check("zero.rd1", RD1, '0);
    end
    RA2 = 3;
    #1 check("init_write_dropped", RD2, '0);

    // bypass then storage, entry 5
    RegWriteW = 1; MemtoRegW = 0; WA3W = 5; LaneMaskW = 3'b111;
    ALUOutW = {18'h3FFFF, 18'h00001, 18'h12345}; RA1 = 5;
    check_all("byp5");
    check("byp5.rd1", RD1, {18'h3FFFF, 18'h00001, 18'h12345});
    tick();
    RegWriteW = 0; ALUOutW = '0;
    check_all("sto5");
    check("sto5.rd1", RD1, {18'h3FFFF, 18'h00001, 18'h12345});

    // lane-masked memory write into entry 7
    RegWriteW = 1; MemtoRegW = 0; WA3W = 7; LaneMaskW = 3'b111;
    ALUOutW = {18'h0AAAA, 18'h0BBBB, 18'h0CCCC};
    tick();
    MemtoRegW = 1; LaneMaskW = 3'b010; ReadDataW = {18'h11111, 18'h22222, 18'h33333};
    RA1 = 7;
    check_all("mask7");
    check("mask7.resultw", ResultW, {18'h11111, 18'h22222, 18'h33333});
    tick();
    RegWriteW = 0;
    check_all("mask7_sto");
    check("mask7.rd1", RD1, {18'h0AAAA, 18'h22222, 18'h0CCCC});

    // same address on both ports with concurrent partial write to 9
    MemtoRegW = 0; RegWriteW = 1; WA3W = 9; LaneMaskW = 3'b111;
    ALUOutW = {18'h01234, 18'h05678, 18'h09ABC};
    tick();
    LaneMaskW = 3'b101; ALUOutW = {18'h3C3C3, 18'h2D2D2, 18'h1E1E1};
    RA1 = 9; RA2 = 9;
    check_all("dual9");
    check("dual9.same", RD1, RD2);
    check("dual9.rd2", RD2, {18'h3C3C3, 18'h05678, 18'h1E1E1});
    tick();

    // no-op write with empty mask, result remembered via the expected queue
    RegWriteW = 1; WA3W = 9; LaneMaskW = 3'b000; ALUOutW = '1;
    exp_q.push_back({18'h3C3C3, 18'h05678, 18'h1E1E1});
    tick();
    RegWriteW = 0; RA1 = 9;
    #1 check("nomask9", RD1, exp_q.pop_front());

    // randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 400; c++) begin
      drive_random();
      if ($urandom_range(0, 149) == 0) begin
        assert_reset();
        check_all("rnd_rst");
        tick();
        reset = 1'b0;
      end
      check_all("rnd");
      tick();
    end

    // reset pulsed mid-sweep restarts the full sweep
    drive_idle();
    assert_reset();
    tick();
    reset = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    assert_reset();
    check("midsweep.rst_ready", W'(ready), '0);
    tick();
    reset = 1'b0;
    for (int e = 0; e < 16; e++) begin
      check("midsweep.wait", W'(ready), '0);
      check_all("midsweep");
      tick();
    end
    check("midsweep.ready", W'(ready), W'(1));
    v = '0;
    RA1 = 5;
    #1 check("midsweep.rd1", RD1, v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
